// File: rtl/rom_stream_reader.sv
// Walks ROM addresses for a burst of `length` entries and streams each registered
// byte on a valid/ready interface with full throughput and stall-safe holding.
module rom_stream_reader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              load, accept;

  assign accept = valid_q && m_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign load   = (remaining_q != '0) && (!valid_q || m_ready);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length != '0) begin
            addr_d      = start_addr;
            remaining_d = length;
            state_d     = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d     = StIdle;
          valid_d     = 1'b0;
          last_d      = 1'b0;
          remaining_d = '0;
        end else if (accept && last_q) begin
          state_d = StIdle;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else if (load) begin
          data_d      = rom_data;
          valid_d     = 1'b1;
          last_d      = (remaining_q == LEN_W'(1));
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
        end else if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = done_q;
  assign rom_addr = addr_q;
  assign m_valid  = valid_q;
  assign m_data   = data_q;
  assign m_last   = last_q;

endmodule
